// File: rtl/mem_viewer_pkg.sv
// mem_viewer shared definitions:
// FSM state encodings and 7-segment decode.
package mem_viewer_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_LATCH = 2'd2;
  localparam logic [1:0] ST_SHOW  = 2'd3;

  localparam logic [6:0] SEG_ZERO = 7'b1000000;

  // {g,f,e,d,c,b,a}, active-low
  function automatic logic [6:0] hex7(
    input logic [3:0] nib
  );
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/mem_viewer_btn_debounce.sv
// Push-button conditioning: synchronizer,
// stability counter, one-cycle rising pulse.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic pulse
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CMAX =
    CW'(DEBOUNCE_CYCLES - 1);

  logic          s1;
  logic          s2;
  logic          level;
  logic          level_d;
  logic [CW-1:0] cnt;

  // two-flop synchronizer for the raw button
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= btn;
      s2 <= s1;
    end
  end

  // flip level after enough consecutive differing samples
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt   <= '0;
      level <= 1'b0;
    end else if (s2 == level) begin
      cnt <= '0;
    end else if (cnt == CMAX) begin
      cnt   <= '0;
      level <= s2;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  // registered rising-edge detect of the debounced level
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      level_d <= 1'b0;
      pulse   <= 1'b0;
    end else begin
      level_d <= level;
      pulse   <= level & ~level_d;
    end
  end

endmodule

// File: rtl/mem_viewer.sv
// Data-memory viewer: walks word addresses,
// latches read data, drives 8-digit 7-seg mux.
module mem_viewer
  import mem_viewer_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE = 32'h0,
  parameter int NUM_WORDS       = 64,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int DWELL_CYCLES    = 32,
  parameter int REFRESH_CYCLES  = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        btn_next,
  input  logic        auto_mode,
  input  logic [31:0] rdata,
  output logic [31:0] addr,
  output logic [31:0] word,
  output logic [7:0]  word_idx,
  output logic        word_valid,
  output logic [7:0]  an,
  output logic [6:0]  segments
);

  localparam int DW = $clog2(DWELL_CYCLES + 1);
  localparam int RW = $clog2(REFRESH_CYCLES + 1);
  localparam logic [7:0] LAST =
    8'(NUM_WORDS - 1);
  localparam logic [DW-1:0] DMAX =
    DW'(DWELL_CYCLES - 1);
  localparam logic [RW-1:0] RMAX =
    RW'(REFRESH_CYCLES - 1);

  logic [1:0]    state;
  logic [7:0]    idx;
  logic          pending;
  logic [DW-1:0] dwell;
  logic          expire_q;
  logic [RW-1:0] rcnt;
  logic [2:0]    digit;
  logic          step;
  logic          adv;
  logic [7:0]    idx_nxt;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn (
    .clk  (clk),
    .reset(reset),
    .btn  (btn_next),
    .pulse(step)
  );

  assign idx_nxt = (idx == LAST) ? 8'd0
                                 : idx + 8'd1;

  // dwell compare is registered, so auto
  // advance fires one cycle after the match
  assign adv = (state == ST_SHOW) &&
               (step || pending ||
                (auto_mode && expire_q));

  assign word_valid = (state == ST_LATCH);

  // walk FSM, address, capture and dwell timer
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_IDLE;
      idx      <= 8'd0;
      addr     <= ADDR_BASE;
      word     <= 32'd0;
      word_idx <= 8'd0;
      pending  <= 1'b0;
      dwell    <= '0;
      expire_q <= 1'b0;
    end else begin
      unique case (1'b1)
        state == ST_IDLE: begin
          if (step) pending <= 1'b1;
          state <= ST_FETCH;
        end
        state == ST_FETCH: begin
          if (step) pending <= 1'b1;
          addr  <= ADDR_BASE +
                   {22'd0, idx, 2'b00};
          state <= ST_LATCH;
        end
        state == ST_LATCH: begin
          if (step) pending <= 1'b1;
          word     <= rdata;
          word_idx <= idx;
          dwell    <= '0;
          expire_q <= 1'b0;
          state    <= ST_SHOW;
        end
        default: begin
          if (adv) begin
            idx      <= idx_nxt;
            pending  <= 1'b0;
            dwell    <= '0;
            expire_q <= 1'b0;
            state    <= ST_FETCH;
          end else if (auto_mode) begin
            dwell    <= dwell + DW'(1);
            expire_q <= (dwell == DMAX);
          end else begin
            dwell    <= '0;
            expire_q <= 1'b0;
          end
        end
      endcase
    end
  end

  // digit scan: each digit lit REFRESH_CYCLES
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rcnt  <= '0;
      digit <= 3'd0;
    end else if (rcnt == RMAX) begin
      rcnt  <= '0;
      digit <= digit + 3'd1;
    end else begin
      rcnt <= rcnt + RW'(1);
    end
  end

  assign an = ~(8'd1 << digit);
  assign segments =
    hex7(word[{digit, 2'b00} +: 4]);

endmodule

// File: tb/tb_mem_viewer.sv
// Directed bench for mem_viewer: reset, button,
// debounce, pending step, auto wrap, display.
module tb_mem_viewer;

  logic        clk = 1'b0;
  logic        rst_a, rst_b;
  logic        btn_a, btn_b;
  logic        auto_a, auto_b;
  logic [31:0] rdata_a, rdata_b;
  logic [31:0] addr_a, addr_b;
  logic [31:0] word_a, word_b;
  logic [7:0]  widx_a, widx_b;
  logic        wv_a, wv_b;
  logic [7:0]  an_a, an_b;
  logic [6:0]  seg_a, seg_b;
  int          mode;
  int          n_chk = 0;
  int          n_fail = 0;

  logic [7:0] exp_an  [8];
  logic [6:0] exp_seg [8];

  always #5 clk = ~clk;

  always_comb begin
    rdata_a = 32'hFEDC_BA98;
    if (mode == 0) rdata_a = 32'h1234_5678;
    else if (mode == 1)
      rdata_a = addr_a ^ 32'hA5A5_A5A5;
  end

  assign rdata_b = addr_b ^ 32'hA5A5_A5A5;

  mem_viewer u_a (
    .clk(clk), .reset(rst_a),
    .btn_next(btn_a), .auto_mode(auto_a),
    .rdata(rdata_a), .addr(addr_a),
    .word(word_a), .word_idx(widx_a),
    .word_valid(wv_a), .an(an_a),
    .segments(seg_a)
  );

  mem_viewer #(.NUM_WORDS(4)) u_b (
    .clk(clk), .reset(rst_b),
    .btn_next(btn_b), .auto_mode(auto_b),
    .rdata(rdata_b), .addr(addr_b),
    .word(word_b), .word_idx(widx_b),
    .word_valid(wv_b), .an(an_b),
    .segments(seg_b)
  );

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    mode = 0; auto_a = 0; btn_a = 0;
    rst_a = 0;
    repeat (3) cyc();
    n_chk += 4;
    if (addr_a !== 32'h0 || word_a !== 32'h0) begin
      n_fail++;
      $display("FAIL rst_hold addr=%h word=%h want 0 0",
               addr_a, word_a);
    end
    if (wv_a !== 1'b0 || widx_a !== 8'h0) begin
      n_fail++;
      $display("FAIL rst_hold wv=%b idx=%h want 0 0",
               wv_a, widx_a);
    end
    if (an_a !== 8'hFE) begin
      n_fail++;
      $display("FAIL rst_an got %h want fe", an_a);
    end
    if (seg_a !== 7'b1000000) begin
      n_fail++;
      $display("FAIL rst_seg got %b want 1000000", seg_a);
    end
    rst_a = 1;
    cyc();
    n_chk++;
    if (wv_a !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_c1_wv got %b want 0", wv_a);
    end
    cyc();
    n_chk += 2;
    if (wv_a !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_c2_wv got %b want 1", wv_a);
    end
    if (addr_a !== 32'h0) begin
      n_fail++;
      $display("FAIL rst_c2_addr got %h want 0", addr_a);
    end
    cyc();
    n_chk += 3;
    if (word_a !== 32'h1234_5678) begin
      n_fail++;
      $display("FAIL rst_word got %h want 12345678",
               word_a);
    end
    if (an_a !== 8'hFE || widx_a !== 8'h0) begin
      n_fail++;
      $display("FAIL rst_c3 an=%h idx=%h want fe 00",
               an_a, widx_a);
    end
    if (seg_a !== 7'b0000000) begin
      n_fail++;
      $display("FAIL rst_c3_seg got %b want 0000000",
               seg_a);
    end
  endtask

  task automatic test_button();
    int nwv = 0;
    int first = -1;
    mode = 1;
    repeat (10) cyc();
    btn_a = 1;
    for (int c = 1; c <= 60; c++) begin
      cyc();
      if (c == 20) btn_a = 0;
      if (wv_a === 1'b1) begin
        nwv++;
        if (first < 0) first = c;
      end
    end
    n_chk += 5;
    if (nwv != 1) begin
      n_fail++;
      $display("FAIL btn_count got %0d want 1", nwv);
    end
    if (first != 21) begin
      n_fail++;
      $display("FAIL btn_latency got %0d want 21", first);
    end
    if (addr_a !== 32'h4) begin
      n_fail++;
      $display("FAIL btn_addr got %h want 4", addr_a);
    end
    if (word_a !== 32'hA5A5_A5A1) begin
      n_fail++;
      $display("FAIL btn_word got %h want a5a5a5a1",
               word_a);
    end
    if (widx_a !== 8'd1) begin
      n_fail++;
      $display("FAIL btn_idx got %0d want 1", widx_a);
    end
  endtask

  task automatic test_bounce();
    int nwv = 0;
    for (int i = 0; i < 10; i++) begin
      btn_a = (i % 2 == 0);
      repeat (3) begin
        cyc();
        if (wv_a === 1'b1) nwv++;
      end
    end
    btn_a = 1;
    repeat (40) begin
      cyc();
      if (wv_a === 1'b1) nwv++;
    end
    btn_a = 0;
    repeat (30) begin
      cyc();
      if (wv_a === 1'b1) nwv++;
    end
    n_chk += 3;
    if (nwv != 1) begin
      n_fail++;
      $display("FAIL bounce_count got %0d want 1", nwv);
    end
    if (widx_a !== 8'd2 || addr_a !== 32'h8) begin
      n_fail++;
      $display("FAIL bounce_pos idx=%0d addr=%h want 2 8",
               widx_a, addr_a);
    end
    if (word_a !== 32'hA5A5_A5AD) begin
      n_fail++;
      $display("FAIL bounce_word got %h want a5a5a5ad",
               word_a);
    end
  endtask

  task automatic test_pending();
    int found = 0;
    int w1 = -1;
    int w2 = -1;
    auto_a = 1;
    for (int i = 0; i < 100 && found == 0; i++) begin
      cyc();
      if (wv_a === 1'b1) found = 1;
    end
    n_chk++;
    if (found == 0) begin
      n_fail++;
      $display("FAIL pend_sync got 0 want 1");
    end
    repeat (15) cyc();
    btn_a = 1;
    for (int k = 16; k <= 45; k++) begin
      cyc();
      if (wv_a === 1'b1) begin
        if (w1 < 0) w1 = k;
        else if (w2 < 0) w2 = k;
      end
    end
    btn_a = 0;
    auto_a = 0;
    n_chk += 3;
    if (w1 != 35) begin
      n_fail++;
      $display("FAIL pend_wv1 got %0d want 35", w1);
    end
    if (w2 != 38) begin
      n_fail++;
      $display("FAIL pend_wv2 got %0d want 38", w2);
    end
    if (widx_a !== 8'd5) begin
      n_fail++;
      $display("FAIL pend_idx got %0d want 5", widx_a);
    end
    repeat (30) cyc();
  endtask

  task automatic test_reset_mid();
    int n = 0;
    mode = 1;
    rst_a = 0;
    cyc();
    rst_a = 1;
    auto_a = 1;
    for (int i = 0; i < 250 && n < 6; i++) begin
      cyc();
      if (wv_a === 1'b1) n++;
    end
    n_chk += 2;
    if (n != 6) begin
      n_fail++;
      $display("FAIL mid_reach got %0d want 6", n);
    end
    if (addr_a !== 32'h14 || widx_a !== 8'd4) begin
      n_fail++;
      $display("FAIL mid_latch addr=%h idx=%0d want 14 4",
               addr_a, widx_a);
    end
    rst_a = 0;
    auto_a = 0;
    #1;
    n_chk += 4;
    if (wv_a !== 1'b0 || addr_a !== 32'h0) begin
      n_fail++;
      $display("FAIL mid_rst wv=%b addr=%h want 0 0",
               wv_a, addr_a);
    end
    if (word_a !== 32'h0 || widx_a !== 8'h0) begin
      n_fail++;
      $display("FAIL mid_rst word=%h idx=%h want 0 0",
               word_a, widx_a);
    end
    if (an_a !== 8'hFE) begin
      n_fail++;
      $display("FAIL mid_rst_an got %h want fe", an_a);
    end
    if (seg_a !== 7'b1000000) begin
      n_fail++;
      $display("FAIL mid_rst_seg got %b want 1000000",
               seg_a);
    end
    cyc();
    rst_a = 1;
    cyc();
    cyc();
    n_chk++;
    if (wv_a !== 1'b1 || addr_a !== 32'h0) begin
      n_fail++;
      $display("FAIL mid_restart wv=%b addr=%h want 1 0",
               wv_a, addr_a);
    end
    cyc();
    n_chk++;
    if (word_a !== 32'hA5A5_A5A5 ||
        widx_a !== 8'h0) begin
      n_fail++;
      $display("FAIL mid_restart word=%h idx=%h want a5a5a5a5 0",
               word_a, widx_a);
    end
  endtask

  task automatic test_display();
    logic [7:0] prev;
    int al = 0;
    mode = 2;
    repeat (5) cyc();
    btn_a = 1;
    repeat (25) cyc();
    btn_a = 0;
    repeat (30) cyc();
    n_chk++;
    if (word_a !== 32'hFEDC_BA98 || widx_a !== 8'd1) begin
      n_fail++;
      $display("FAIL disp_word got %h/%0d want fedcba98/1",
               word_a, widx_a);
    end
    prev = an_a;
    for (int i = 0; i < 40 && al == 0; i++) begin
      cyc();
      if (prev == 8'h7F && an_a == 8'hFE) al = 1;
      prev = an_a;
    end
    n_chk++;
    if (al == 0) begin
      n_fail++;
      $display("FAIL disp_align got 0 want 1");
    end
    for (int k = 0; k < 32; k++) begin
      n_chk += 2;
      if (an_a !== exp_an[k/4]) begin
        n_fail++;
        $display("FAIL disp_an k=%0d got %h want %h",
                 k, an_a, exp_an[k/4]);
      end
      if (seg_a !== exp_seg[k/4]) begin
        n_fail++;
        $display("FAIL disp_seg k=%0d got %b want %b",
                 k, seg_a, exp_seg[k/4]);
      end
      cyc();
    end
  endtask

  task automatic test_auto_wrap();
    int n = 0;
    int cy [5];
    logic [31:0] ad [5];
    logic [7:0]  ix [5];
    logic [7:0]  exp_ix [5];
    logic [31:0] exp_ad [5];
    int grab = -1;
    exp_ix = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd0};
    exp_ad = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h0};
    for (int i = 0; i < 5; i++) begin
      cy[i] = -1; ad[i] = 'x; ix[i] = 'x;
    end
    auto_b = 1;
    rst_b = 1;
    for (int c = 1; c <= 170; c++) begin
      cyc();
      if (grab >= 0) begin
        ix[grab] = widx_b;
        grab = -1;
      end
      if (wv_b === 1'b1 && n < 5) begin
        cy[n] = c;
        ad[n] = addr_b;
        grab = n;
        n++;
      end
    end
    n_chk += 2;
    if (n != 5) begin
      n_fail++;
      $display("FAIL auto_count got %0d want 5", n);
    end
    if (cy[0] != 2) begin
      n_fail++;
      $display("FAIL auto_first got %0d want 2", cy[0]);
    end
    for (int i = 0; i < 5; i++) begin
      n_chk += 2;
      if (ix[i] !== exp_ix[i]) begin
        n_fail++;
        $display("FAIL auto_idx%0d got %0d want %0d",
                 i, ix[i], exp_ix[i]);
      end
      if (ad[i] !== exp_ad[i]) begin
        n_fail++;
        $display("FAIL auto_addr%0d got %h want %h",
                 i, ad[i], exp_ad[i]);
      end
      if (i > 0) begin
        n_chk++;
        if (cy[i] - cy[i-1] != 35) begin
          n_fail++;
          $display("FAIL auto_gap%0d got %0d want 35",
                   i, cy[i] - cy[i-1]);
        end
      end
    end
    n_chk++;
    if (word_b !== 32'hA5A5_A5A5) begin
      n_fail++;
      $display("FAIL auto_word got %h want a5a5a5a5",
               word_b);
    end
  endtask

  initial begin
    exp_an = '{8'hFE, 8'hFD, 8'hFB, 8'hF7,
               8'hEF, 8'hDF, 8'hBF, 8'h7F};
    exp_seg = '{7'b0000000, 7'b0010000,
                7'b0001000, 7'b0000011,
                7'b1000110, 7'b0100001,
                7'b0000110, 7'b0001110};
    rst_a = 0; rst_b = 0;
    btn_a = 0; btn_b = 0;
    auto_a = 0; auto_b = 0;
    mode = 0;
    @(negedge clk);
    test_reset();
    test_button();
    test_bounce();
    test_pending();
    test_reset_mid();
    test_display();
    test_auto_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
